// File: rtl/pix_packer.sv
// Packs scalar 1/2/4/8-bit pixels into DWD-bit lane-packed words (lane k at [k*W +: W]).
// One-entry output register with valid/ready on both the pixel and the word side.
package pe_ctl_cfg_pkg;
  typedef enum logic [2:0] {
    MODE_XNOR = 3'd0,
    MODE_M1   = 3'd1,
    MODE_M2   = 3'd2,
    MODE_M4   = 3'd3,
    MODE_M8   = 3'd4
  } pe_mode_e;
endpackage

module pix_packer
  import pe_ctl_cfg_pkg::*;
#(
  parameter int DWD   = 16,
  parameter int CNTWD = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  pe_mode_e                 i_mode,
  input  logic [7:0]               i_pix,
  input  logic                     i_pix_last,
  input  logic                     i_pix_valid,
  output logic                     o_pix_ready,
  output logic [DWD-1:0]           o_word,
  output logic [$clog2(DWD):0]     o_word_lanes,
  output logic                     o_word_last,
  output logic                     o_word_valid,
  input  logic                     i_word_ready,
  output logic [CNTWD-1:0]         o_word_cnt
);

  localparam int LNW = $clog2(DWD) + 1;
  localparam int SHW = LNW + 3;

  // Handshake rule: a pixel moves when i_pix_valid && o_pix_ready, a word
  // moves when o_word_valid && i_word_ready; word fields hold while stalled.

  function automatic logic [1:0] width_log2(input pe_mode_e m);
    case (m)
      MODE_M2: width_log2 = 2'd1;
      MODE_M4: width_log2 = 2'd2;
      MODE_M8: width_log2 = 2'd3;
      default: width_log2 = 2'd0;
    endcase
  endfunction

  logic [DWD-1:0]   pk_q, pk_d;
  logic [LNW-1:0]   cnt_q, cnt_d;
  pe_mode_e         lmode_q, lmode_d;
  logic [DWD-1:0]   word_q, word_d;
  logic [LNW-1:0]   lanes_q, lanes_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;
  logic [CNTWD-1:0] wcnt_q, wcnt_d;

  pe_mode_e         cur_mode;
  logic [1:0]       cur_wl;
  logic [LNW-1:0]   lanes_cur;
  logic [LNW-1:0]   cnt_inc;
  logic [7:0]       pix_mask;
  logic [7:0]       pix_m;
  logic [SHW-1:0]   shamt;
  logic [DWD-1:0]   merged;
  logic             complete;
  logic             pix_ready;
  logic             accept;
  logic             handoff;

  // The first pixel of a word picks the width; later pixels reuse the latched mode.
  assign cur_mode  = (cnt_q == '0) ? i_mode : lmode_q;
  assign cur_wl    = width_log2(cur_mode);
  assign lanes_cur = LNW'(DWD) >> cur_wl;
  assign cnt_inc   = cnt_q + LNW'(1);

  always_comb begin
    case (cur_wl)
      2'd0:    pix_mask = 8'h01;
      2'd1:    pix_mask = 8'h03;
      2'd2:    pix_mask = 8'h0F;
      default: pix_mask = 8'hFF;
    endcase
  end

  assign pix_m     = i_pix & pix_mask;
  assign shamt     = SHW'(cnt_q) << cur_wl;
  assign merged    = pk_q | (DWD'(pix_m) << shamt);
  assign complete  = (cnt_inc == lanes_cur) || i_pix_last;

  assign pix_ready = !valid_q || i_word_ready;
  assign accept    = i_pix_valid && pix_ready;
  assign handoff   = valid_q && i_word_ready;

  always_comb begin
    pk_d    = pk_q;
    cnt_d   = cnt_q;
    lmode_d = lmode_q;
    word_d  = word_q;
    lanes_d = lanes_q;
    last_d  = last_q;
    valid_d = valid_q;
    wcnt_d  = wcnt_q;
    if (handoff) begin
      valid_d = 1'b0;
      wcnt_d  = wcnt_q + CNTWD'(1);
    end
    if (accept) begin
      if (cnt_q == '0) begin
        lmode_d = i_mode;
      end
      if (complete) begin
        // A completing accept in the handoff cycle reloads and keeps valid high.
        word_d  = merged;
        lanes_d = cnt_inc;
        last_d  = i_pix_last;
        valid_d = 1'b1;
        pk_d    = '0;
        cnt_d   = '0;
      end else begin
        pk_d    = merged;
        cnt_d   = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pk_q    <= '0;
      cnt_q   <= '0;
      lmode_q <= MODE_M1;
      word_q  <= '0;
      lanes_q <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      pk_q    <= pk_d;
      cnt_q   <= cnt_d;
      lmode_q <= lmode_d;
      word_q  <= word_d;
      lanes_q <= lanes_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign o_pix_ready  = pix_ready;
  assign o_word       = word_q;
  assign o_word_lanes = lanes_q;
  assign o_word_last  = last_q;
  assign o_word_valid = valid_q;
  assign o_word_cnt   = wcnt_q;

endmodule

// File: tb/tb_pix_packer.sv
// Bench for pix_packer: directed scenarios plus randomized traffic, scored against
// a queue-based model that assembles each word from its accepted pixels.
module tb_pix_packer;
  import pe_ctl_cfg_pkg::*;

  localparam int DWD   = 16;
  localparam int CNTWD = 16;
  localparam int LNW   = $clog2(DWD) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  pe_mode_e         i_mode = MODE_M1;
  logic [7:0]       i_pix = '0;
  logic             i_pix_last = 1'b0;
  logic             i_pix_valid = 1'b0;
  logic             i_word_ready = 1'b1;
  logic             o_pix_ready;
  logic [DWD-1:0]   o_word;
  logic [LNW-1:0]   o_word_lanes;
  logic             o_word_last;
  logic             o_word_valid;
  logic [CNTWD-1:0] o_word_cnt;

  pix_packer #(.DWD(DWD), .CNTWD(CNTWD)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_mode       (i_mode),
    .i_pix        (i_pix),
    .i_pix_last   (i_pix_last),
    .i_pix_valid  (i_pix_valid),
    .o_pix_ready  (o_pix_ready),
    .o_word       (o_word),
    .o_word_lanes (o_word_lanes),
    .o_word_last  (o_word_last),
    .o_word_valid (o_word_valid),
    .i_word_ready (i_word_ready),
    .o_word_cnt   (o_word_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model / scoreboard ----------------
  logic [DWD-1:0]   exp_q[$];
  logic [LNW-1:0]   exp_lanes_q[$];
  logic             exp_last_q[$];
  logic [7:0]       model_pix[$];
  int               model_w = 1;
  logic [CNTWD-1:0] exp_cnt = '0;
  logic             mon_on = 1'b0;
  logic             prev_stall = 1'b0;
  logic [DWD-1:0]   held_word;
  logic [LNW-1:0]   held_lanes;
  logic             held_last;

  function automatic int width_of(input pe_mode_e m);
    case (m)
      MODE_M2: return 2;
      MODE_M4: return 4;
      MODE_M8: return 8;
      default: return 1;
    endcase
  endfunction

  task automatic model_emit(input logic last);
    logic [63:0] acc;
    acc = 64'd0;
    for (int k = 0; k < model_pix.size(); k++)
      acc = acc + 64'(model_pix[k]) * (64'd1 << (k * model_w));
    exp_q.push_back(acc[DWD-1:0]);
    exp_lanes_q.push_back(LNW'(model_pix.size()));
    exp_last_q.push_back(last);
    model_pix.delete();
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_lanes_q.delete();
      exp_last_q.delete();
      model_pix.delete();
      exp_cnt    = '0;
      prev_stall = 1'b0;
    end else if (mon_on) begin
      checks++;
      if ($isunknown({o_pix_ready, o_word, o_word_lanes, o_word_last, o_word_valid, o_word_cnt})) begin
        errors++;
        $display("FAIL no_x: outputs contain X/Z at %0t", $time);
      end
      checks++;
      if (o_word_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL word_cnt: got %0d expected %0d at %0t", o_word_cnt, exp_cnt, $time);
      end
      checks++;
      if (o_pix_ready !== (!o_word_valid || i_word_ready)) begin
        errors++;
        $display("FAIL pix_ready: got %0b valid=%0b ready=%0b at %0t", o_pix_ready, o_word_valid, i_word_ready, $time);
      end
      if (o_word_valid) begin
        checks++;
        if (o_word_lanes < 1 || o_word_lanes > DWD) begin
          errors++;
          $display("FAIL lanes_range: got %0d at %0t", o_word_lanes, $time);
        end
      end
      if (prev_stall && o_word_valid) begin
        checks++;
        if (o_word !== held_word || o_word_lanes !== held_lanes || o_word_last !== held_last) begin
          errors++;
          $display("FAIL hold: got %h/%0d/%0b expected %h/%0d/%0b at %0t",
                   o_word, o_word_lanes, o_word_last, held_word, held_lanes, held_last, $time);
        end
      end
      if (o_word_valid && i_word_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got word %h with nothing expected at %0t", o_word, $time);
        end else begin
          logic [DWD-1:0] ew;
          logic [LNW-1:0] el;
          logic           elast;
          ew    = exp_q.pop_front();
          el    = exp_lanes_q.pop_front();
          elast = exp_last_q.pop_front();
          if (o_word !== ew || o_word_lanes !== el || o_word_last !== elast) begin
            errors++;
            $display("FAIL sb_word: got %h/%0d/%0b expected %h/%0d/%0b at %0t",
                     o_word, o_word_lanes, o_word_last, ew, el, elast, $time);
          end
        end
        exp_cnt = exp_cnt + CNTWD'(1);
      end
      prev_stall = o_word_valid && !i_word_ready;
      held_word  = o_word;
      held_lanes = o_word_lanes;
      held_last  = o_word_last;
      if (i_pix_valid && o_pix_ready) begin
        if (model_pix.size() == 0) model_w = width_of(i_mode);
        model_pix.push_back(i_pix & 8'((1 << model_w) - 1));
        if (model_pix.size() == DWD / model_w || i_pix_last) model_emit(i_pix_last);
      end
    end
  end

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic send_pix(input pe_mode_e m, input logic [7:0] p, input logic last);
    int n;
    i_mode      = m;
    i_pix       = p;
    i_pix_last  = last;
    i_pix_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!o_pix_ready && n < 1000) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (!o_pix_ready) begin
      errors++;
      $display("FAIL send_timeout: o_pix_ready stuck at %0b, required 1", o_pix_ready);
    end
    @(posedge clk); #1;
    i_pix_valid = 1'b0;
    i_pix_last  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic check_word(input string name, input logic [DWD-1:0] w,
                            input logic [LNW-1:0] l, input logic last);
    checks++;
    if (o_word_valid !== 1'b1 || o_word !== w || o_word_lanes !== l || o_word_last !== last) begin
      errors++;
      $display("FAIL %s: got v=%0b %h/%0d/%0b expected v=1 %h/%0d/%0b",
               name, o_word_valid, o_word, o_word_lanes, o_word_last, w, l, last);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_on = 1'b1;
    checks++;
    if (o_word !== '0 || o_word_lanes !== '0 || o_word_last !== 1'b0 ||
        o_word_valid !== 1'b0 || o_word_cnt !== '0 || o_pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got %h/%0d/%0b v=%0b cnt=%0d rdy=%0b expected all 0, rdy=1",
               o_word, o_word_lanes, o_word_last, o_word_valid, o_word_cnt, o_pix_ready);
    end
  endtask

  task automatic test_m4_basic();
    i_word_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send_pix(MODE_M4, 8'(i), 1'b0);
    check_word("m4_word", 16'h4321, LNW'(4), 1'b0);
    checks++;
    if (o_word_cnt !== 16'd0) begin
      errors++;
      $display("FAIL m4_cnt_before: got %0d expected 0", o_word_cnt);
    end
    idle();
    checks++;
    if (o_word_valid !== 1'b0 || o_word_cnt !== 16'd1) begin
      errors++;
      $display("FAIL m4_after: got v=%0b cnt=%0d expected v=0 cnt=1", o_word_valid, o_word_cnt);
    end
  endtask

  task automatic test_m2_last_m8();
    send_pix(MODE_M2, 8'd3, 1'b0);
    send_pix(MODE_M2, 8'd1, 1'b0);
    send_pix(MODE_M2, 8'd2, 1'b1);
    check_word("m2_last", 16'h0027, LNW'(3), 1'b1);
    send_pix(MODE_M8, 8'hAB, 1'b0);
    send_pix(MODE_M8, 8'hCD, 1'b0);
    check_word("m8_pair", 16'hCDAB, LNW'(2), 1'b0);
    idle();
  endtask

  task automatic test_m1_upper_bits();
    for (int i = 0; i < 16; i++)
      send_pix(MODE_M1, {7'($urandom), (i % 2 == 0)}, 1'b0);
    check_word("m1_alt", 16'h5555, LNW'(16), 1'b0);
    idle();
  endtask

  task automatic test_back_to_back();
    logic [CNTWD-1:0] base;
    base = exp_cnt;
    i_word_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_pix(MODE_M4, 8'(i), 1'b0);
      end
      begin
        int n;
        n = 0;
        while (!o_word_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          checks++;
          if (o_word !== 16'h3210 || o_word_valid !== 1'b1 || o_pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall: got %h v=%0b rdy=%0b expected 3210 v=1 rdy=0",
                     o_word, o_word_valid, o_pix_ready);
          end
        end
        @(posedge clk); #1;
        i_word_ready = 1'b1;
      end
    join
    check_word("bp_second", 16'h7654, LNW'(4), 1'b0);
    idle();
    checks++;
    if (o_word_cnt !== base + CNTWD'(2) || o_word_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_cnt: got cnt=%0d v=%0b expected cnt=%0d v=0", o_word_cnt, o_word_valid, base + CNTWD'(2));
    end
  endtask

  task automatic test_mode_change();
    send_pix(MODE_M4, 8'h05, 1'b0);
    send_pix(MODE_M8, 8'h06, 1'b0);
    send_pix(MODE_M8, 8'h07, 1'b0);
    send_pix(MODE_M8, 8'h08, 1'b0);
    check_word("mode_hold", 16'h8765, LNW'(4), 1'b0);
    send_pix(MODE_M8, 8'h12, 1'b0);
    send_pix(MODE_M8, 8'h34, 1'b0);
    check_word("mode_next", 16'h3412, LNW'(2), 1'b0);
    idle();
  endtask

  task automatic test_reset_mid();
    send_pix(MODE_M4, 8'h1, 1'b0);
    send_pix(MODE_M4, 8'h2, 1'b0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    checks++;
    if (o_word !== '0 || o_word_lanes !== '0 || o_word_last !== 1'b0 ||
        o_word_valid !== 1'b0 || o_word_cnt !== '0 || o_pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_a: got %h/%0d/%0b v=%0b cnt=%0d rdy=%0b expected all 0, rdy=1",
               o_word, o_word_lanes, o_word_last, o_word_valid, o_word_cnt, o_pix_ready);
    end
    send_pix(MODE_M4, 8'h9, 1'b0);
    send_pix(MODE_M4, 8'hA, 1'b0);
    send_pix(MODE_M4, 8'hB, 1'b0);
    send_pix(MODE_M4, 8'hC, 1'b0);
    check_word("reset_a_word", 16'hCBA9, LNW'(4), 1'b0);
    idle();
    i_word_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_pix(MODE_M4, 8'(i), 1'b0);
    check_word("reset_b_pending", 16'h4321, LNW'(4), 1'b0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    checks++;
    if (o_word_valid !== 1'b0 || o_word_cnt !== '0 || o_pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_b: got v=%0b cnt=%0d rdy=%0b expected v=0 cnt=0 rdy=1",
               o_word_valid, o_word_cnt, o_pix_ready);
    end
    i_word_ready = 1'b1;
    idle();
  endtask

  task automatic test_random();
    logic done;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 7) == 0) idle();
          send_pix(pe_mode_e'($urandom_range(0, 4)), 8'($urandom),
                   ($urandom_range(0, 11) == 0) || (i == 399));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          i_word_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        i_word_ready = 1'b1;
      end
    join
    repeat (4) idle();
    checks++;
    if (exp_q.size() != 0 || model_pix.size() != 0) begin
      errors++;
      $display("FAIL random_drain: got %0d words and %0d pixels outstanding, expected 0 and 0",
               exp_q.size(), model_pix.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_m4_basic();
    test_m2_last_m8();
    test_m1_upper_bits();
    test_back_to_back();
    test_mode_change();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
